// File: rtl/mcont_to_chnbuf_mux.sv
// mcont_to_chnbuf_mux
// Registered distributor from the memory-controller read-data stream to
// NUM_CHN channel buffers. Decodes the target channel, registers the write
// strobe, page advance, run flag and data, and keeps per-channel word-address
// and page counters so the buffers need no address logic of their own.
// All registers run on the falling edge of clk and reset asynchronously.
//
// Optional feature: define MCONT_CHNBUF_OVERFLOW_EN to add buf_ovf, a sticky
// per-channel flag raised when a write wraps the word counter without a page
// advance in the same cycle.
//
// Ports:
//   clk, rst             memory clock (negedge), async active-high reset
//   ext_buf_wr           data write strobe (channel decoded one cycle earlier)
//   ext_buf_wpage_nxt    page advance for the addressed channel
//   ext_buf_wchn         channel number (values >= NUM_CHN select nothing)
//   ext_buf_wrefresh     refresh cycle, blocks all channel activity
//   ext_buf_wrun         transfer in progress
//   ext_buf_wdata        write data
//   page_rst             per-channel synchronous clear of page/word counters
//   buf_wr_chn           one-hot write strobe
//   buf_wpage_nxt_chn    one-hot page-advance pulse
//   buf_run              one-hot run flag
//   buf_wdata, buf_waddr shared data bus and word address of the write
//   buf_wpage            packed page numbers, channel n at [n*PAGE_BITS +: PAGE_BITS]
//   buf_ovf              (optional) sticky page-overrun flags
module mcont_to_chnbuf_mux #(
  parameter int NUM_CHN      = 16,
  parameter int CHN_BITS     = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_BITS    = 6,
  parameter int PAGE_BITS    = 2,
  parameter int EXTRA_STAGES = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ext_buf_wr,
  input  logic                           ext_buf_wpage_nxt,
  input  logic [CHN_BITS-1:0]            ext_buf_wchn,
  input  logic                           ext_buf_wrefresh,
  input  logic                           ext_buf_wrun,
  input  logic [DATA_WIDTH-1:0]          ext_buf_wdata,
  input  logic [NUM_CHN-1:0]             page_rst,
  output logic [NUM_CHN-1:0]             buf_wr_chn,
  output logic [NUM_CHN-1:0]             buf_wpage_nxt_chn,
  output logic [NUM_CHN-1:0]             buf_run,
  output logic [DATA_WIDTH-1:0]          buf_wdata,
  output logic [ADDR_BITS-1:0]           buf_waddr,
  output logic [NUM_CHN*PAGE_BITS-1:0]   buf_wpage
`ifdef MCONT_CHNBUF_OVERFLOW_EN
  ,
  output logic [NUM_CHN-1:0]             buf_ovf
`endif
);

  localparam int BASE_W = 3*NUM_CHN + DATA_WIDTH + ADDR_BITS + NUM_CHN*PAGE_BITS;
`ifdef MCONT_CHNBUF_OVERFLOW_EN
  localparam int PW = BASE_W + NUM_CHN;
`else
  localparam int PW = BASE_W;
`endif

  logic [NUM_CHN-1:0]           sel, sel_r, wr, pnxt;
  logic [NUM_CHN-1:0]           wr_q, pnxt_q, run_q;
  logic [DATA_WIDTH-1:0]        data_q;
  logic [ADDR_BITS-1:0]         addr_q, waddr_nxt;
  logic [ADDR_BITS-1:0]         word_cnt [NUM_CHN];
  logic [NUM_CHN*PAGE_BITS-1:0] page_q;
  logic [PW-1:0]                stage0, stage_out;

  // Same-cycle decode; out-of-range channel numbers match no channel.
  always_comb begin
    sel = '0;
    for (int n = 0; n < NUM_CHN; n++)
      sel[n] = (ext_buf_wchn == CHN_BITS'(n)) && !ext_buf_wrefresh;
  end

  // Writes use the decode registered one cycle earlier; page advance and run
  // use the same-cycle decode.
  assign wr   = sel_r & {NUM_CHN{ext_buf_wr}};
  assign pnxt = sel   & {NUM_CHN{ext_buf_wpage_nxt}};

  // wr is one-hot, so OR-ing the gated counters selects the writer's address.
  always_comb begin
    waddr_nxt = '0;
    for (int n = 0; n < NUM_CHN; n++)
      if (wr[n]) waddr_nxt = waddr_nxt | word_cnt[n];
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      sel_r  <= '0;
      wr_q   <= '0;
      pnxt_q <= '0;
      run_q  <= '0;
      data_q <= '0;
      addr_q <= '0;
    end else begin
      sel_r  <= sel;
      wr_q   <= wr;
      pnxt_q <= pnxt;
      run_q  <= sel & {NUM_CHN{ext_buf_wrun}};
      if (|wr) begin
        data_q <= ext_buf_wdata;
        addr_q <= waddr_nxt;
      end
    end
  end

  // page_rst beats a page advance, which beats the post-write increment.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_CHN; n++) word_cnt[n] <= '0;
      page_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CHN; n++) begin
        if (page_rst[n]) begin
          word_cnt[n]                      <= '0;
          page_q[n*PAGE_BITS +: PAGE_BITS] <= '0;
        end else if (pnxt[n]) begin
          word_cnt[n]                      <= '0;
          page_q[n*PAGE_BITS +: PAGE_BITS] <= page_q[n*PAGE_BITS +: PAGE_BITS] + PAGE_BITS'(1);
        end else if (wr[n]) begin
          word_cnt[n] <= word_cnt[n] + ADDR_BITS'(1);
        end
      end
    end
  end

`ifdef MCONT_CHNBUF_OVERFLOW_EN
  logic [NUM_CHN-1:0] ovf_q;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      for (int n = 0; n < NUM_CHN; n++) begin
        if (page_rst[n])
          ovf_q[n] <= 1'b0;
        else if (wr[n] && (word_cnt[n] == {ADDR_BITS{1'b1}}) && !pnxt[n])
          ovf_q[n] <= 1'b1;
      end
    end
  end

  assign stage0 = {wr_q, pnxt_q, run_q, data_q, addr_q, page_q, ovf_q};
  assign {buf_wr_chn, buf_wpage_nxt_chn, buf_run, buf_wdata, buf_waddr, buf_wpage, buf_ovf} = stage_out;
`else
  assign stage0 = {wr_q, pnxt_q, run_q, data_q, addr_q, page_q};
  assign {buf_wr_chn, buf_wpage_nxt_chn, buf_run, buf_wdata, buf_waddr, buf_wpage} = stage_out;
`endif

  // All outputs travel together through the optional delay line so they stay aligned.
  generate
    if (EXTRA_STAGES == 0) begin : g_nodly
      assign stage_out = stage0;
    end else begin : g_dly
      logic [PW-1:0] dly [EXTRA_STAGES];

      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < EXTRA_STAGES; k++) dly[k] <= '0;
        end else begin
          dly[0] <= stage0;
          for (int k = 1; k < EXTRA_STAGES; k++) dly[k] <= dly[k-1];
        end
      end

      assign stage_out = dly[EXTRA_STAGES-1];
    end
  endgenerate

endmodule

// File: tb/tb_mcont_to_chnbuf_mux.sv
module tb_mcont_to_chnbuf_mux;

  typedef struct packed {
    logic [15:0] wr;
    logic [15:0] pn;
    logic [15:0] run;
    logic [63:0] data;
    logic [5:0]  addr;
    logic [31:0] page;
    logic [15:0] ovf;
  } outs_t;

  typedef struct packed {
    logic        wr, pn, rf, run;
    logic [4:0]  chn;
    logic [63:0] data;
    logic [15:0] prst;
    outs_t       exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_i, pn_i, rf_i, run_i;
  logic [4:0]  chn_i;
  logic [63:0] data_i;
  logic [15:0] prst_i;

  logic [15:0] a_wr, a_pn, a_run, b_wr, b_pn, b_run;
  logic [63:0] a_data, b_data;
  logic [5:0]  a_addr, b_addr;
  logic [31:0] a_page, b_page;
`ifdef MCONT_CHNBUF_OVERFLOW_EN
  logic [15:0] a_ovf, b_ovf;
`endif

  outs_t act_a, act_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcont_to_chnbuf_mux #(.CHN_BITS(5), .EXTRA_STAGES(0)) dut_a (
    .clk(clk), .rst(rst),
    .ext_buf_wr(wr_i), .ext_buf_wpage_nxt(pn_i), .ext_buf_wchn(chn_i),
    .ext_buf_wrefresh(rf_i), .ext_buf_wrun(run_i), .ext_buf_wdata(data_i),
    .page_rst(prst_i),
    .buf_wr_chn(a_wr), .buf_wpage_nxt_chn(a_pn), .buf_run(a_run),
    .buf_wdata(a_data), .buf_waddr(a_addr), .buf_wpage(a_page)
`ifdef MCONT_CHNBUF_OVERFLOW_EN
    , .buf_ovf(a_ovf)
`endif
  );

  mcont_to_chnbuf_mux #(.CHN_BITS(5), .EXTRA_STAGES(2)) dut_b (
    .clk(clk), .rst(rst),
    .ext_buf_wr(wr_i), .ext_buf_wpage_nxt(pn_i), .ext_buf_wchn(chn_i),
    .ext_buf_wrefresh(rf_i), .ext_buf_wrun(run_i), .ext_buf_wdata(data_i),
    .page_rst(prst_i),
    .buf_wr_chn(b_wr), .buf_wpage_nxt_chn(b_pn), .buf_run(b_run),
    .buf_wdata(b_data), .buf_waddr(b_addr), .buf_wpage(b_page)
`ifdef MCONT_CHNBUF_OVERFLOW_EN
    , .buf_ovf(b_ovf)
`endif
  );

  always_comb begin
    act_a = '0;
    act_a.wr = a_wr; act_a.pn = a_pn; act_a.run = a_run;
    act_a.data = a_data; act_a.addr = a_addr; act_a.page = a_page;
    act_b = '0;
    act_b.wr = b_wr; act_b.pn = b_pn; act_b.run = b_run;
    act_b.data = b_data; act_b.addr = b_addr; act_b.page = b_page;
`ifdef MCONT_CHNBUF_OVERFLOW_EN
    act_a.ovf = a_ovf;
    act_b.ovf = b_ovf;
`endif
  end

  // Reference model: per-channel counters as plain integers.
  int          m_word [16];
  int          m_page [16];
  logic [15:0] m_ovf;
  int          m_prev_sel;
  logic [63:0] m_data;
  int          m_addr;
  outs_t       dq [$];

  task automatic model_reset();
    for (int c = 0; c < 16; c++) begin m_word[c] = 0; m_page[c] = 0; end
    m_ovf = '0; m_prev_sel = -1; m_data = '0; m_addr = 0;
    dq.delete();
    dq.push_back(outs_t'(0));
    dq.push_back(outs_t'(0));
  endtask

  task automatic model_step(output outs_t e);
    int cur, wch;
    cur = (!rf_i && chn_i < 5'd16) ? int'(chn_i) : -1;
    wch = (wr_i && m_prev_sel >= 0) ? m_prev_sel : -1;
    e = '0;
    if (wch >= 0) e.wr[wch] = 1'b1;
    if (cur >= 0 && run_i) e.run[cur] = 1'b1;
    if (cur >= 0 && pn_i)  e.pn[cur]  = 1'b1;
    if (wch >= 0) begin
      m_data = data_i;
      m_addr = m_word[wch];
      if (m_word[wch] == 63 && !e.pn[wch]) m_ovf[wch] = 1'b1;
    end
    for (int c = 0; c < 16; c++) begin
      if (prst_i[c]) begin
        m_word[c] = 0; m_page[c] = 0; m_ovf[c] = 1'b0;
      end else if (e.pn[c]) begin
        m_word[c] = 0; m_page[c] = (m_page[c] + 1) % 4;
      end else if (wch == c) begin
        m_word[c] = (m_word[c] + 1) % 64;
      end
    end
    m_prev_sel = cur;
    e.data = m_data;
    e.addr = 6'(m_addr);
    for (int c = 0; c < 16; c++) e.page[c*2 +: 2] = 2'(m_page[c]);
`ifdef MCONT_CHNBUF_OVERFLOW_EN
    e.ovf = m_ovf;
`endif
  endtask

  task automatic chk(input string name, input outs_t act, input outs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got wr=%h pn=%h run=%h data=%h addr=%h page=%h ovf=%h, want wr=%h pn=%h run=%h data=%h addr=%h page=%h ovf=%h",
               name, act.wr, act.pn, act.run, act.data, act.addr, act.page, act.ovf,
               exp.wr, exp.pn, exp.run, exp.data, exp.addr, exp.page, exp.ovf);
    end
  endtask

  task automatic chk1(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    wr_i = 0; pn_i = 0; rf_i = 0; run_i = 0; chn_i = '0; data_i = '0; prst_i = '0;
  endtask

  // Inputs are set before the call; outputs are sampled 1 ns after the negedge.
  task automatic step(input string name);
    outs_t e;
    model_step(e);
    @(negedge clk); #1;
    chk({name, "_a"}, act_a, e);
    dq.push_back(e);
    if (dq.size() > 3) void'(dq.pop_front());
    chk({name, "_b"}, act_b, dq[0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    zero_inputs();
    @(negedge clk); #1;
    chk("reset_a", act_a, outs_t'(0));
    chk("reset_b", act_b, outs_t'(0));
    rst = 1'b0;
    model_reset();
  endtask

  task automatic rst_async();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_a", act_a, outs_t'(0));
    chk("rst_mid_b", act_b, outs_t'(0));
    zero_inputs();
    @(negedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  vec_t vec [17];

  task automatic add(input int i, input logic wr, input logic pn, input logic rf, input logic run,
                     input logic [4:0] chn, input logic [63:0] d, input logic [15:0] prst,
                     input logic [15:0] ewr, input logic [15:0] epn, input logic [15:0] erun,
                     input logic [63:0] ed, input logic [5:0] ea, input logic [31:0] ep);
    vec[i].wr = wr; vec[i].pn = pn; vec[i].rf = rf; vec[i].run = run;
    vec[i].chn = chn; vec[i].data = d; vec[i].prst = prst;
    vec[i].exp = '0;
    vec[i].exp.wr = ewr; vec[i].exp.pn = epn; vec[i].exp.run = erun;
    vec[i].exp.data = ed; vec[i].exp.addr = ea; vec[i].exp.page = ep;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //  i  wr pn rf run chn data  prst    | wr      pn      run     data  addr page
    add( 0, 0, 0, 0, 1,  3, 'h00, 'h0000,  'h0000, 'h0000, 'h0008, 'h00, 0, 'h000);
    add( 1, 1, 0, 0, 1,  3, 'hA0, 'h0000,  'h0008, 'h0000, 'h0008, 'hA0, 0, 'h000);
    add( 2, 1, 0, 0, 1,  3, 'hA1, 'h0000,  'h0008, 'h0000, 'h0008, 'hA1, 1, 'h000);
    add( 3, 1, 0, 0, 1,  3, 'hA2, 'h0000,  'h0008, 'h0000, 'h0008, 'hA2, 2, 'h000);
    add( 4, 1, 1, 0, 1,  3, 'hA3, 'h0000,  'h0008, 'h0008, 'h0008, 'hA3, 3, 'h040);
    add( 5, 1, 0, 0, 1,  3, 'hA4, 'h0000,  'h0008, 'h0000, 'h0008, 'hA4, 0, 'h040);
    add( 6, 0, 1, 1, 1,  3, 'hFF, 'h0000,  'h0000, 'h0000, 'h0000, 'hA4, 0, 'h040);
    add( 7, 1, 1, 1, 1,  3, 'hFF, 'h0000,  'h0000, 'h0000, 'h0000, 'hA4, 0, 'h040);
    add( 8, 0, 0, 0, 0,  3, 'h00, 'h0000,  'h0000, 'h0000, 'h0000, 'hA4, 0, 'h040);
    add( 9, 1, 0, 0, 0,  3, 'hB0, 'h0000,  'h0008, 'h0000, 'h0000, 'hB0, 1, 'h040);
    add(10, 0, 1, 0, 0,  5, 'h00, 'h0000,  'h0000, 'h0020, 'h0000, 'hB0, 1, 'h440);
    add(11, 0, 1, 0, 0,  5, 'h00, 'h0000,  'h0000, 'h0020, 'h0000, 'hB0, 1, 'h840);
    add(12, 0, 1, 0, 0,  5, 'h00, 'h0000,  'h0000, 'h0020, 'h0000, 'hB0, 1, 'hC40);
    add(13, 0, 1, 0, 0,  5, 'h00, 'h0000,  'h0000, 'h0020, 'h0000, 'hB0, 1, 'h040);
    add(14, 0, 1, 0, 0,  5, 'h00, 'h0020,  'h0000, 'h0020, 'h0000, 'hB0, 1, 'h040);
    add(15, 0, 1, 0, 1, 20, 'h00, 'h0000,  'h0000, 'h0000, 'h0000, 'hB0, 1, 'h040);
    add(16, 1, 1, 0, 1, 20, 'hC0, 'h0000,  'h0000, 'h0000, 'h0000, 'hB0, 1, 'h040);

    rst = 1'b1;
    zero_inputs();
    model_reset();
    #3;
    do_reset();

    for (int i = 0; i < 17; i++) begin
      wr_i = vec[i].wr; pn_i = vec[i].pn; rf_i = vec[i].rf; run_i = vec[i].run;
      chn_i = vec[i].chn; data_i = vec[i].data; prst_i = vec[i].prst;
      step("tbl");
      chk($sformatf("tbl_vec%0d", i), act_a, vec[i].exp);
    end

    // Mid-burst reset clears every output of both builds at once.
    chn_i = 5'd3; wr_i = 0;
    step("burst");
    for (int i = 0; i < 3; i++) begin
      wr_i = 1; data_i = 64'hD0 + 64'(i);
      step("burst");
    end
    rst_async();

    // Word counter wrap (and overrun flag when built in) on channel 0.
    do_reset();
    chn_i = 5'd0; wr_i = 0;
    step("wrap");
    for (int i = 1; i <= 65; i++) begin
      wr_i = 1; data_i = 64'(i);
      step("wrap");
`ifdef MCONT_CHNBUF_OVERFLOW_EN
      if (i == 63) chk1("ovf_before", 64'(a_ovf[0]), 64'd0);
      if (i == 64) chk1("ovf_set", 64'(a_ovf[0]), 64'd1);
`endif
    end
    chk1("wrap_addr", 64'(a_addr), 64'd0);
    wr_i = 0;
    for (int i = 0; i < 3; i++) step("ovf_hold");
    prst_i = 16'h0001;
    step("ovf_clr");
    prst_i = '0;
`ifdef MCONT_CHNBUF_OVERFLOW_EN
    chk1("ovf_cleared", 64'(a_ovf[0]), 64'd0);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) chn_i = 5'($urandom_range(19));
      wr_i   = ($urandom_range(9) < 7);
      pn_i   = ($urandom_range(19) == 0);
      rf_i   = ($urandom_range(19) == 0);
      run_i  = 1'($urandom_range(1));
      data_i = {$urandom, $urandom};
      prst_i = ($urandom_range(49) == 0) ? (16'h1 << $urandom_range(15)) : 16'h0;
      step("rand");
      if (i == 1500) rst_async();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
